// File: rtl/ldpc_runner_if.sv
// ldpc_runner_if: bus between the channel LLR source / control and the runner.
//   en             continuous-scan enable
//   ini_st         start request (rising edge starts a pass)
//   in_info_wren   LLR write enable
//   rece_llr_intri one signed LLR per column, lane k = column k
//   llr_sign       per-column hard-decision flag (argmax != 0)
interface ldpc_runner_if #(
    parameter int unsigned LLR_WIDTH  = 8,
    parameter int unsigned ROW_WEIGHT = 24
);
    logic                                 en;
    logic                                 ini_st;
    logic                                 in_info_wren;
    logic [ROW_WEIGHT-1:0][LLR_WIDTH-1:0] rece_llr_intri;
    logic [ROW_WEIGHT-1:0]                llr_sign;

    modport master (
        output en, ini_st, in_info_wren, rece_llr_intri,
        input  llr_sign
    );

    modport slave (
        input  en, ini_st, in_info_wren, rece_llr_intri,
        output llr_sign
    );
endinterface

// File: rtl/ldpc_runner.sv
// ldpc_runner: loads 24 columns x 256 signed LLRs, then scans every column in
// parallel for its most-likely GF(256) symbol and publishes a 24-bit flag
// vector (bit k set when column k's decided symbol is nonzero).
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ldpc_runner_if.slave (write port, start/continuous control, llr_sign)
module ldpc_runner (
    input  logic          clk,
    input  logic          rst,
    ldpc_runner_if.slave  bus
);
    localparam int unsigned LLR_WIDTH  = 8;
    localparam int unsigned ROW_WEIGHT = 24;
    localparam int unsigned GF_SIZE    = 256;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned CNT_W      = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic                        ini_d;
    logic                        start;
    logic [ADDR_W-1:0]           wr_addr;
    logic                        wr_en;
    logic [CNT_W-1:0]            rd_cnt;
    logic [ADDR_W-1:0]           rd_addr;
    logic                        scan_last;
    logic                        cmp_valid;
    logic [ADDR_W-1:0]           cmp_idx;
    logic [ROW_WEIGHT-1:0]       llr_sign_q;

    logic signed [LLR_WIDTH-1:0] mem     [ROW_WEIGHT][GF_SIZE];
    logic signed [LLR_WIDTH-1:0] rd_data [ROW_WEIGHT];
    logic signed [LLR_WIDTH-1:0] max_val [ROW_WEIGHT];
    logic        [ADDR_W-1:0]    arg_max [ROW_WEIGHT];

    assign start     = bus.ini_st & ~ini_d;
    assign wr_en     = bus.in_info_wren && (state == IDLE) && !rst;
    assign rd_addr   = rd_cnt[ADDR_W-1:0];
    // rd_cnt reaches GF_SIZE on the cycle the last symbol is being compared
    assign scan_last = (rd_cnt == CNT_W'(GF_SIZE));
    // rd_data lags rd_cnt by one, so the symbol under compare is rd_cnt-1
    assign cmp_valid = (state == SCAN) && (rd_cnt != '0);
    assign cmp_idx   = rd_addr - ADDR_W'(1);
    assign bus.llr_sign = llr_sign_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (scan_last) state_next = DONE;
            DONE:    state_next = bus.en ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Start edge detect and write pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ini_d   <= 1'b0;
            wr_addr <= '0;
        end else begin
            ini_d <= bus.ini_st;
            if ((state == IDLE) && start) wr_addr <= '0;
            else if (wr_en)               wr_addr <= wr_addr + ADDR_W'(1);
        end
    end

    // Read counter: runs 0..GF_SIZE during SCAN, parked at 0 otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 rd_cnt <= '0;
        else if (state == SCAN)  rd_cnt <= rd_cnt + CNT_W'(1);
        else                     rd_cnt <= '0;
    end

    // LLR storage with one-cycle synchronous read; contents survive reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < ROW_WEIGHT; k++) begin
            if (wr_en) mem[k][wr_addr] <= bus.rece_llr_intri[k];
            if ((state == SCAN) && !rd_cnt[CNT_W-1]) rd_data[k] <= mem[k][rd_addr];
        end
    end

    // Per-column running max; strict greater-than keeps the lowest index on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ROW_WEIGHT; k++) begin
                max_val[k] <= '0;
                arg_max[k] <= '0;
            end
        end else if (cmp_valid) begin
            for (int k = 0; k < ROW_WEIGHT; k++) begin
                if ((cmp_idx == '0) || (rd_data[k] > max_val[k])) begin
                    max_val[k] <= rd_data[k];
                    arg_max[k] <= cmp_idx;
                end
            end
        end
    end

    // Hard-decision flags, loaded once per pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llr_sign_q <= '0;
        end else if (state == DONE) begin
            for (int k = 0; k < ROW_WEIGHT; k++) llr_sign_q[k] <= (arg_max[k] != '0);
        end
    end
endmodule

// File: tb/tb_ldpc_runner.sv
// tb_ldpc_runner: randomized and directed frames checked against an argmax
// reference model computed directly from the stored frame.
module tb_ldpc_runner;
    localparam int unsigned LLR_WIDTH  = 8;
    localparam int unsigned ROW_WEIGHT = 24;
    localparam int unsigned GF_SIZE    = 256;
    localparam int unsigned LAT        = 258;

    logic clk;
    logic rst;

    ldpc_runner_if #(.LLR_WIDTH(LLR_WIDTH), .ROW_WEIGHT(ROW_WEIGHT)) bus ();

    ldpc_runner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int m [ROW_WEIGHT][GF_SIZE];
    logic [ROW_WEIGHT-1:0] prev;
    logic [ROW_WEIGHT-1:0] exp_v;

    task automatic check(input string tag, input logic [ROW_WEIGHT-1:0] got,
                         input logic [ROW_WEIGHT-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%06h want=%06h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: index of the largest value, earliest index wins ties
    function automatic logic [ROW_WEIGHT-1:0] ref_sign();
        logic [ROW_WEIGHT-1:0] r;
        for (int k = 0; k < ROW_WEIGHT; k++) begin
            int best;
            best = 0;
            for (int s = 1; s < GF_SIZE; s++)
                if (m[k][s] > m[k][best]) best = s;
            r[k] = (best != 0);
        end
        return r;
    endfunction

    task automatic fill_all(input int v);
        for (int k = 0; k < ROW_WEIGHT; k++)
            for (int s = 0; s < GF_SIZE; s++) m[k][s] = v;
    endtask

    task automatic fill_random();
        for (int k = 0; k < ROW_WEIGHT; k++) begin
            for (int s = 0; s < GF_SIZE; s++) m[k][s] = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 2) == 0) m[k][0] = 127;
        end
    endtask

    task automatic load_frame();
        for (int a = 0; a < GF_SIZE; a++) begin
            bus.in_info_wren = 1'b1;
            for (int k = 0; k < ROW_WEIGHT; k++) bus.rece_llr_intri[k] = 8'(m[k][a]);
            tick();
        end
        bus.in_info_wren = 1'b0;
    endtask

    // Start a pass; ini_st held for `hold` edges, optional extra rising edge mid-scan
    task automatic run_pass(input string tag, input int hold, input bit rise2,
                            input logic [ROW_WEIGHT-1:0] old_v,
                            input logic [ROW_WEIGHT-1:0] want);
        bus.ini_st = 1'b1;
        tick();
        for (int c = 1; c <= int'(LAT); c++) begin
            if (c == hold) bus.ini_st = 1'b0;
            if (rise2 && c == 100) bus.ini_st = 1'b1;
            if (rise2 && c == 105) bus.ini_st = 1'b0;
            tick();
            if (c == int'(LAT) - 1) check({tag, "_early"}, bus.llr_sign, old_v);
            if (c == int'(LAT))     check(tag, bus.llr_sign, want);
        end
        bus.ini_st = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.en = 1'b0;
        bus.ini_st = 1'b0;
        bus.in_info_wren = 1'b0;
        bus.rece_llr_intri = '0;
        repeat (3) tick();
        check("reset_sign", bus.llr_sign, '0);
        rst = 1'b0;
        tick();

        // All columns peak at symbol 0
        fill_all(-50);
        for (int k = 0; k < ROW_WEIGHT; k++) m[k][0] = 100;
        load_frame();
        exp_v = ref_sign();
        run_pass("sym0_peak", 2, 1'b0, '0, exp_v);
        repeat (300) tick();
        check("held_en0", bus.llr_sign, exp_v);
        prev = exp_v;

        // Every column peaks at a nonzero symbol
        fill_all(-128);
        for (int k = 1; k < ROW_WEIGHT; k++) m[k][k+1] = 127;
        m[0][255] = 127;
        load_frame();
        exp_v = ref_sign();
        run_pass("all_nonzero", 1, 1'b0, prev, exp_v);
        prev = exp_v;

        // Ties keep the lowest index
        fill_random();
        for (int s = 0; s < GF_SIZE; s++) begin
            m[3][s] = -100;
            m[5][s] = -100;
        end
        m[3][0] = 20; m[3][7] = 20;
        m[5][9] = 20; m[5][4] = 20;
        load_frame();
        exp_v = ref_sign();
        run_pass("ties", 1, 1'b0, prev, exp_v);
        prev = exp_v;

        // Signed compare: all-negative column, and 0x80 never beats 0x7F
        fill_random();
        for (int s = 0; s < GF_SIZE; s++) begin
            m[2][s] = -5;
            m[6][s] = -128;
            m[7][s] = -128;
        end
        m[2][200] = -1;
        m[6][0] = 127;
        m[7][1] = 127;
        load_frame();
        exp_v = ref_sign();
        run_pass("signed", 1, 1'b0, prev, exp_v);
        prev = exp_v;

        // Long ini_st plus second rising edge mid-scan: one update only
        fill_random();
        for (int k = 0; k < ROW_WEIGHT; k += 2) m[k][0] = 127;
        load_frame();
        exp_v = ref_sign();
        run_pass("held_start", 10, 1'b1, prev, exp_v);
        repeat (300) tick();
        check("held_start_stable", bus.llr_sign, exp_v);
        prev = exp_v;

        // Continuous mode: identical refresh every pass
        fill_random();
        for (int k = 1; k < ROW_WEIGHT; k += 2) m[k][0] = 127;
        load_frame();
        exp_v = ref_sign();
        bus.en = 1'b1;
        run_pass("cont_p0", 1, 1'b0, prev, exp_v);
        for (int r = 1; r <= 2; r++) begin
            repeat (LAT - 1) tick();
            check("cont_mid", bus.llr_sign, exp_v);
            tick();
            check("cont_refresh", bus.llr_sign, exp_v);
        end
        bus.en = 1'b0;
        repeat (600) tick();
        prev = exp_v;

        // Random frames
        for (int i = 0; i < 6; i++) begin
            fill_random();
            load_frame();
            exp_v = ref_sign();
            run_pass("random", 1 + i, 1'b0, prev, exp_v);
            prev = exp_v;
        end

        // Reset mid-pass with write enable active: no writes may land
        fill_all(-50);
        for (int k = 0; k < ROW_WEIGHT; k++) m[k][0] = 0;
        load_frame();
        bus.ini_st = 1'b1;
        tick();
        bus.ini_st = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        bus.in_info_wren = 1'b1;
        for (int k = 0; k < ROW_WEIGHT; k++) bus.rece_llr_intri[k] = 8'h80;
        repeat (10) tick();
        check("reset_mid", bus.llr_sign, '0);
        rst = 1'b0;
        bus.in_info_wren = 1'b0;
        tick();
        check("reset_after", bus.llr_sign, '0);
        exp_v = ref_sign();
        run_pass("post_reset", 1, 1'b0, '0, exp_v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
